mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single memory port between the instruction-fetch requester (control unit) and the data load/store requester (execute/memory stage). It uses the memory's memExecute/memReady/dataReady handshake.
- Latches the winning request and issues exactly one memory transaction at a time.
- Returns read data plus a one-cycle ack to the granted requester.
- Gives a watchdog error if memory never answers.
It replaces the ad-hoc address/size muxing by state code in the top level.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, WAIT cycles without dataReady before error completion (1..255; counter is 8 bits)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  AW  fetch address (always word, unsigned, read)
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DW  fetch data, valid while if_ack=1, held until next fetch ack
if_err  out  1  qualifies if_ack: transaction timed out
d_req  in  1  data request, level, held until d_ack
d_write  in  1  1=store, 0=load
d_size  in  2  00 byte, 01 half, 10 word
d_sign  in  1  1=sign-extend load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DW  load data, valid while d_ack=1
d_err  out  1  qualifies d_ack: transaction timed out
memReady  in  1  memory idle, can accept memExecute
dataReady  in  1  memory completion pulse, memRdata valid
memRdata  in  DW  memory read data
memExecute  out  1  one-cycle issue strobe
memWrite  out  1  registered transaction write flag
memSize  out  2  registered size
memSign  out  1  registered sign flag
memAddress  out  AW  registered address
memWdata  out  DW  registered store data
busy  out  1  state != IDLE
grant_d  out  1  current or last grant was the data port

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs drive 0, including if_rdata/d_rdata and the mem* registers.
  - The timeout counter is 0.
  - Rotation pointer (if enabled) points to fetch.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If memReady=1 and (if_req|d_req), arbitrate and latch the winner's attributes into the mem* registers, then go to ISSUE.
  - Fetch attributes are forced: write=0, size=10, sign=0, wdata=0.
  - Otherwise stay in IDLE.
  - dataReady is ignored in IDLE (stray or late responses are dropped).
- Arbitration (default): fixed priority, data over fetch, so a pending load/store always wins a simultaneous request.
- ISSUE:
  - memExecute=1 for exactly this cycle; the counter clears.
  - Go to WAIT.
  - dataReady is ignored in this cycle.
- WAIT:
  - mem* registers hold stable and memExecute=0.
  - If dataReady=1: capture memRdata into the granted rdata register (write transactions also capture it, so the value is don't-care), set err=0, go to RESP.
  - Else if counter==TIMEOUT-1: capture 0, set err=1, go to RESP.
  - Else counter+1.
- RESP:
  - Granted ack=1 and err valid for exactly one cycle; the other ack stays 0.
  - Go to IDLE.
  - The requester must drop req by the cycle after ack; a req still high in IDLE is treated as a new request.
- Latency: request seen in IDLE at cycle 0 → memExecute at cycle 1 → dataReady at cycle N → ack at cycle N+1. Minimum round trip is 3 cycles (dataReady at cycle 2). Next issue is no earlier than cycle N+2.
- Request changes:
  - The loser's req is not consumed and stays pending.
  - Requester attribute changes after the IDLE sample do not affect the in-flight transaction.
  - Deasserting req mid-transaction does not abort it; ack is still produced.
- memReady=0 in IDLE: no issue, requests wait indefinitely (no timeout in IDLE).
- Reset mid-transaction: the transaction is abandoned with no ack; any later dataReady from memory is ignored in IDLE.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: simultaneous requests alternate. A one-bit pointer updates in RESP to favour the non-granted port. Single requests are always served.
- Undefined: fixed data-over-fetch priority; the pointer logic is absent.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, memReady=1, dataReady 2 cycles after memExecute with memRdata=0x00000013 → memSize=10, memWrite=0, if_ack one cycle with if_rdata=0x13, if_err=0, d_ack=0.
- Store: d_req=1, d_write=1, d_size=00, d_addr=0x2004, d_wdata=0xA5 → memWrite=1, memSize=00, memAddress=0x2004, memWdata=0xA5 held through WAIT; d_ack one cycle.
- Simultaneous if_req and d_req for 4 transactions: default order D,D,D,D while both are held; with ARB_ROUND_ROBIN_EN the order is D,F,D,F.
- Timeout: issue, dataReady never asserted, TIMEOUT=4 → d_ack with d_err=1 and d_rdata=0 exactly 4 WAIT cycles after ISSUE; a late dataReady afterwards causes no ack.
- Backpressure: memReady=0 for 10 cycles with if_req=1 → no memExecute, busy=0; memReady→1 → memExecute next cycle.
- Reset mid-WAIT: assert reset=0 asynchronously → all outputs 0 immediately; release, then dataReady pulse → no ack; a new if_req is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// load/store. A winner is latched in IDLE, issued with a one-cycle memExecute,
// awaited in WAIT (with a watchdog), and acknowledged for one cycle in RESP.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous
// requests instead of the default fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [1:0]    d_size,
  input  logic          d_sign,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  input  logic          memReady,
  input  logic          dataReady,
  input  logic [DW-1:0] memRdata,
  output logic          memExecute,
  output logic          memWrite,
  output logic [1:0]    memSize,
  output logic          memSign,
  output logic [AW-1:0] memAddress,
  output logic [DW-1:0] memWdata,
  output logic          busy,
  output logic          grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Last WAIT cycle value of the watchdog counter before giving up.
  localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  logic [7:0]    r_count;
  logic          r_memExecute;
  logic          r_memWrite;
  logic [1:0]    r_memSize;
  logic          r_memSign;
  logic [AW-1:0] r_memAddress;
  logic [DW-1:0] r_memWdata;
  logic          r_ifAck;
  logic          r_ifErr;
  logic [DW-1:0] r_ifRdata;
  logic          r_dAck;
  logic          r_dErr;
  logic [DW-1:0] r_dRdata;
  logic          r_grantD;
  logic          w_pickD;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer remembers whether the last served port was data; 0 (fetch) after
  // reset so the first contested grant goes to data.
  logic r_rrLastD;
  assign w_pickD = d_req & (~if_req | ~r_rrLastD);
`else
  assign w_pickD = d_req;
`endif

  assign memExecute = r_memExecute;
  assign memWrite   = r_memWrite;
  assign memSize    = r_memSize;
  assign memSign    = r_memSign;
  assign memAddress = r_memAddress;
  assign memWdata   = r_memWdata;
  assign if_ack     = r_ifAck;
  assign if_err     = r_ifErr;
  assign if_rdata   = r_ifRdata;
  assign d_ack      = r_dAck;
  assign d_err      = r_dErr;
  assign d_rdata    = r_dRdata;
  assign grant_d    = r_grantD;
  assign busy       = (r_state != IDLE);

  // Transaction sequencer: arbitrate, issue, wait with watchdog, acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_memExecute <= 1'b0;
      r_memWrite   <= 1'b0;
      r_memSize    <= '0;
      r_memSign    <= 1'b0;
      r_memAddress <= '0;
      r_memWdata   <= '0;
      r_ifAck      <= 1'b0;
      r_ifErr      <= 1'b0;
      r_ifRdata    <= '0;
      r_dAck       <= 1'b0;
      r_dErr       <= 1'b0;
      r_dRdata     <= '0;
      r_grantD     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rrLastD    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (memReady && (if_req || d_req)) begin
            r_grantD     <= w_pickD;
            r_memExecute <= 1'b1;
            r_state      <= ISSUE;
            if (w_pickD) begin
              r_memWrite   <= d_write;
              r_memSize    <= d_size;
              r_memSign    <= d_sign;
              r_memAddress <= d_addr;
              r_memWdata   <= d_wdata;
            end else begin
              r_memWrite   <= 1'b0;
              r_memSize    <= 2'b10;
              r_memSign    <= 1'b0;
              r_memAddress <= if_addr;
              r_memWdata   <= '0;
            end
          end
        end
        ISSUE: begin
          r_memExecute <= 1'b0;
          r_count      <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          if (dataReady) begin
            r_state <= RESP;
            if (r_grantD) begin
              r_dRdata <= memRdata;
              r_dAck   <= 1'b1;
              r_dErr   <= 1'b0;
            end else begin
              r_ifRdata <= memRdata;
              r_ifAck   <= 1'b1;
              r_ifErr   <= 1'b0;
            end
          end else if (r_count == LP_TLAST) begin
            r_state <= RESP;
            if (r_grantD) begin
              r_dRdata <= '0;
              r_dAck   <= 1'b1;
              r_dErr   <= 1'b1;
            end else begin
              r_ifRdata <= '0;
              r_ifAck   <= 1'b1;
              r_ifErr   <= 1'b1;
            end
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        RESP: begin
          r_ifAck <= 1'b0;
          r_ifErr <= 1'b0;
          r_dAck  <= 1'b0;
          r_dErr  <= 1'b0;
          r_state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          r_rrLastD <= r_grantD;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
